reg_file_wb_port: RTL and testbench
===================================

Name: reg_file_wb_port

Overview:
- Consumer end of the 2-bit register-file write-data select produced by the writeback controller.
- Decodes the select, picks and formats the writeback data, and registers the write in a one-entry writeback stage.
- Commits the write into a 32 x 32 register file and serves two combinational read ports, with bypass from the pending write.
- Sits between the MEM/WB pipeline register and the decode-stage operand fetch.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 reads as zero.
- ADDR_WIDTH, 5, register address width; NUM_REGS must equal 2**ADDR_WIDTH.
- BYTE_SIGN_EXT, 1, 1 = sign-extend byte loads, 0 = zero-extend.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- w_wb_valid  in  1  writeback request this cycle.
- w_wdata_ctrl_in_2  in  2  data source select: 00 mem word, 01 mem byte, 10 immediate, 11 ALU/link result.
- w_waddr_5  in  ADDR_WIDTH  destination register.
- w_mem_rdata_32  in  32  load data.
- w_mem_addr_lo_2  in  2  low address bits for byte select.
- w_imm_32  in  32  immediate source.
- w_alu_result_32  in  32  ALU or link source.
- w_raddr_a_5, w_raddr_b_5  in  ADDR_WIDTH  read addresses.
- w_rdata_a_32, w_rdata_b_32  out  32  read data.
- w_raw_hazard_out  out  1  read-after-write hazard flag (see Optional Feature).
- w_commit_valid  out  1  write committed to the array this cycle.
- w_commit_addr_5  out  ADDR_WIDTH  committed register address.
- w_commit_data_32  out  32  committed data.

Behaviour:
- Data formatting is combinational on the inputs:
  - 00: w_mem_rdata_32.
  - 01: byte selected big-endian. lo=00 gives [31:24], 01 gives [23:16], 10 gives [15:8], 11 gives [7:0]. Extended per BYTE_SIGN_EXT.
  - 10: w_imm_32.
  - 11: w_alu_result_32.
- Stage 1 (WB register):
  - On each clock edge, captures valid, address and formatted data.
  - valid is captured as w_wb_valid AND (w_waddr_5 != 0); writes to register 0 are dropped here.
  - Select, address and data inputs are don't-care when w_wb_valid=0. X on the select with valid=0 must not propagate.
- Stage 2 (array write):
  - On the next clock edge, if the stage-1 valid is set, the data is written into the array.
  - w_commit_* are registered copies of that write. w_commit_valid is a one-cycle pulse per write.
- Latency:
  - Inputs are presented in cycle N.
  - The write is bypass-visible on read ports from cycle N+1.
  - It is in the array and w_commit_valid=1 in cycle N+2.
- Back-to-back writes are accepted every cycle with no stall. Two consecutive writes to the same register: the later one wins in both bypass and array.
- Read ports are combinational. For each port, in priority order:
  - Address 0 returns 0.
  - Otherwise, if stage-1 valid and the address matches the stage-1 address, return the stage-1 data.
  - Otherwise, return array contents.
  - The two ports are independent; identical addresses return identical data.
- Reset (asynchronous, active-low, any time including mid-write):
  - Stage-1 valid=0.
  - All array entries = 0.
  - w_commit_valid=0, w_commit_addr_5=0, w_commit_data_32=0.
  - Both read ports return 0 for all addresses; w_raw_hazard_out=0.
  - An in-flight write is discarded.
  - After deassertion, the first write needs no extra idle cycle.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined:
  - Stage-1 bypass is enabled as described above.
  - w_raw_hazard_out is tied to 0.
- Undefined:
  - Read ports return array contents only (address 0 still returns 0).
  - w_raw_hazard_out=1 when stage-1 is valid and its address equals either nonzero read address; otherwise 0.
  - The pipeline stalls decode for one cycle on this flag.

Test Plan:
- Reset: hold reset low, then release. Read all 32 addresses on both ports -> all 0. w_commit_valid=0.
- ALU write: valid=1, sel=11, waddr=5, alu=0xDEADBEEF in cycle N.
  - With bypass: port A at addr 5 returns 0xDEADBEEF in N+1.
  - In N+2: w_commit_valid=1, addr=5, data=0xDEADBEEF.
  - Without bypass: hazard=1 in N+1 and port A returns 0; port A returns 0xDEADBEEF in N+2.
- Byte load: sel=01, mem=0x12F45678, lo=01, waddr=7 -> register 7 = 0xFFFFFFF4 (BYTE_SIGN_EXT=1) or 0x000000F4 (BYTE_SIGN_EXT=0). With lo=00 -> 0x00000012.
- Register 0: valid=1, sel=10, waddr=0, imm=0xFFFFFFFF -> no commit pulse; both ports at addr 0 return 0 in every cycle.
- Back-to-back to the same register:
  - Cycle N: sel=10, waddr=3, imm=0x11.
  - Cycle N+1: sel=11, waddr=3, alu=0x22.
  - Required: port B at addr 3 returns 0x11 in N+1 and 0x22 from N+2 onward (bypass).
  - Required: array holds 0x22 after N+3; two commit pulses.
- Reset mid-write: present write to reg 9 (imm=0x55), then assert reset in the next cycle before commit -> no commit pulse; reg 9 reads 0 after release.

Source files
------------

// File: rtl/reg_file_wb_port.sv
// Writeback-side register file: formats the selected writeback source, registers it in a one-entry
// WB stage, commits it to a 32-entry array and serves two read ports. Define REG_FILE_BYPASS_EN for WB-stage bypass.
module reg_file_wb_port #(
    parameter int NUM_REGS      = 32,
    parameter int ADDR_WIDTH    = 5,
    parameter int BYTE_SIGN_EXT = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  w_wb_valid,
    input  logic [1:0]            w_wdata_ctrl_in_2,
    input  logic [ADDR_WIDTH-1:0] w_waddr_5,
    input  logic [31:0]           w_mem_rdata_32,
    input  logic [1:0]            w_mem_addr_lo_2,
    input  logic [31:0]           w_imm_32,
    input  logic [31:0]           w_alu_result_32,
    input  logic [ADDR_WIDTH-1:0] w_raddr_a_5,
    input  logic [ADDR_WIDTH-1:0] w_raddr_b_5,
    output logic [31:0]           w_rdata_a_32,
    output logic [31:0]           w_rdata_b_32,
    output logic                  w_raw_hazard_out,
    output logic                  w_commit_valid,
    output logic [ADDR_WIDTH-1:0] w_commit_addr_5,
    output logic [31:0]           w_commit_data_32
);

    function automatic logic [31:0] fmt_wdata(
        input logic [1:0]  sel,
        input logic [31:0] mem,
        input logic [1:0]  lo,
        input logic [31:0] imm,
        input logic [31:0] alu
    );
        logic [7:0]  b;
        logic [31:0] res;
        // Big-endian byte lanes: offset 0 is the most significant byte.
        case (lo)
            2'b00:   b = mem[31:24];
            2'b01:   b = mem[23:16];
            2'b10:   b = mem[15:8];
            default: b = mem[7:0];
        endcase
        case (sel)
            2'b00:   res = mem;
            2'b01:   res = (BYTE_SIGN_EXT != 0) ? {{24{b[7]}}, b} : {24'h000000, b};
            2'b10:   res = imm;
            default: res = alu;
        endcase
        return res;
    endfunction

    logic [31:0]           wdata_p0;
    logic                  vld_p1;
    logic [ADDR_WIDTH-1:0] waddr_p1;
    logic [31:0]           wdata_p1;
    logic                  vld_p2;
    logic [ADDR_WIDTH-1:0] waddr_p2;
    logic [31:0]           wdata_p2;
    logic [31:0]           regs [NUM_REGS];

    assign wdata_p0 = fmt_wdata(w_wdata_ctrl_in_2, w_mem_rdata_32, w_mem_addr_lo_2,
                                w_imm_32, w_alu_result_32);

    // Stage 1: WB register; writes to register 0 are dropped and data only loads on a request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p1   <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
        end else begin
            vld_p1 <= w_wb_valid && (w_waddr_5 != '0);
            if (w_wb_valid) begin
                waddr_p1 <= w_waddr_5;
                wdata_p1 <= wdata_p0;
            end
        end
    end

    // Stage 2: array write plus registered commit report.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p2   <= 1'b0;
            waddr_p2 <= '0;
            wdata_p2 <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            vld_p2 <= vld_p1;
            if (vld_p1) begin
                regs[waddr_p1] <= wdata_p1;
                waddr_p2       <= waddr_p1;
                wdata_p2       <= wdata_p1;
            end
        end
    end

    assign w_commit_valid   = vld_p2;
    assign w_commit_addr_5  = waddr_p2;
    assign w_commit_data_32 = wdata_p2;

`ifdef REG_FILE_BYPASS_EN
    assign w_rdata_a_32 = (w_raddr_a_5 == '0) ? 32'h0 :
                          (vld_p1 && (waddr_p1 == w_raddr_a_5)) ? wdata_p1 : regs[w_raddr_a_5];
    assign w_rdata_b_32 = (w_raddr_b_5 == '0) ? 32'h0 :
                          (vld_p1 && (waddr_p1 == w_raddr_b_5)) ? wdata_p1 : regs[w_raddr_b_5];
    assign w_raw_hazard_out = 1'b0;
`else
    assign w_rdata_a_32 = (w_raddr_a_5 == '0) ? 32'h0 : regs[w_raddr_a_5];
    assign w_rdata_b_32 = (w_raddr_b_5 == '0) ? 32'h0 : regs[w_raddr_b_5];
    // Decode stalls one cycle while the pending write is not yet visible in the array.
    assign w_raw_hazard_out = vld_p1 &&
                              (((w_raddr_a_5 != '0) && (w_raddr_a_5 == waddr_p1)) ||
                               ((w_raddr_b_5 != '0) && (w_raddr_b_5 == waddr_p1)));
`endif

endmodule

// File: tb/tb_reg_file_wb_port.sv
// Scoreboard bench for reg_file_wb_port: commits are checked by a monitor against a queue of
// expected writes; read ports are checked directly. Expectations follow REG_FILE_BYPASS_EN.
module tb_reg_file_wb_port;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        w_wb_valid = 1'b0;
    logic [1:0]  w_wdata_ctrl_in_2 = 2'b00;
    logic [4:0]  w_waddr_5 = '0;
    logic [31:0] w_mem_rdata_32 = '0;
    logic [1:0]  w_mem_addr_lo_2 = '0;
    logic [31:0] w_imm_32 = '0;
    logic [31:0] w_alu_result_32 = '0;
    logic [4:0]  w_raddr_a_5 = '0;
    logic [4:0]  w_raddr_b_5 = '0;
    logic [31:0] w_rdata_a_32, w_rdata_b_32;
    logic        w_raw_hazard_out;
    logic        w_commit_valid;
    logic [4:0]  w_commit_addr_5;
    logic [31:0] w_commit_data_32;

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q [$];

    reg_file_wb_port dut (
        .clock(clock), .reset(reset),
        .w_wb_valid(w_wb_valid), .w_wdata_ctrl_in_2(w_wdata_ctrl_in_2), .w_waddr_5(w_waddr_5),
        .w_mem_rdata_32(w_mem_rdata_32), .w_mem_addr_lo_2(w_mem_addr_lo_2),
        .w_imm_32(w_imm_32), .w_alu_result_32(w_alu_result_32),
        .w_raddr_a_5(w_raddr_a_5), .w_raddr_b_5(w_raddr_b_5),
        .w_rdata_a_32(w_rdata_a_32), .w_rdata_b_32(w_rdata_b_32),
        .w_raw_hazard_out(w_raw_hazard_out), .w_commit_valid(w_commit_valid),
        .w_commit_addr_5(w_commit_addr_5), .w_commit_data_32(w_commit_data_32)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every commit pulse must match the oldest outstanding expected write.
    always @(negedge clock) begin
        if (w_commit_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_commit: got addr %0d data %h expected no commit",
                         w_commit_addr_5, w_commit_data_32);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                chk("commit_addr", {27'h0, w_commit_addr_5}, {27'h0, e[36:32]});
                chk("commit_data", w_commit_data_32, e[31:0]);
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic issue(input logic [1:0] sel, input logic [4:0] waddr, input logic [31:0] mem,
                         input logic [1:0] lo, input logic [31:0] imm, input logic [31:0] alu,
                         input logic [31:0] exp);
        w_wb_valid        = 1'b1;
        w_wdata_ctrl_in_2 = sel;
        w_waddr_5         = waddr;
        w_mem_rdata_32    = mem;
        w_mem_addr_lo_2   = lo;
        w_imm_32          = imm;
        w_alu_result_32   = alu;
        if (waddr != 5'd0) exp_q.push_back({waddr, exp});
    endtask

    task automatic idle();
        w_wb_valid        = 1'b0;
        w_wdata_ctrl_in_2 = 2'bxx;
        w_waddr_5         = 'x;
    endtask

    task automatic read_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
        w_raddr_a_5 = a;
        w_raddr_b_5 = a;
        #1;
        chk({name, "_a"}, w_rdata_a_32, exp);
        chk({name, "_b"}, w_rdata_b_32, exp);
    endtask

    initial begin
        idle();
        repeat (3) tick();
        chk("rst_commit_valid_held", {31'h0, w_commit_valid}, 32'h0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 32; i++) read_chk("rst_read", i[4:0], 32'h0);
        chk("rst_commit_valid", {31'h0, w_commit_valid}, 32'h0);
        chk("rst_commit_addr", {27'h0, w_commit_addr_5}, 32'h0);
        chk("rst_commit_data", w_commit_data_32, 32'h0);
        chk("rst_hazard", {31'h0, w_raw_hazard_out}, 32'h0);

        // ALU write to r5
        tick();
        w_raddr_a_5 = 5'd5;
        w_raddr_b_5 = 5'd0;
        issue(2'b11, 5'd5, 32'h0, 2'b00, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF);
        tick();
        idle();
`ifdef REG_FILE_BYPASS_EN
        chk("alu_n1_rdata", w_rdata_a_32, 32'hDEADBEEF);
        chk("alu_n1_hazard", {31'h0, w_raw_hazard_out}, 32'h0);
`else
        chk("alu_n1_rdata", w_rdata_a_32, 32'h0);
        chk("alu_n1_hazard", {31'h0, w_raw_hazard_out}, 32'h1);
`endif
        tick();
        chk("alu_n2_rdata", w_rdata_a_32, 32'hDEADBEEF);
        chk("alu_n2_hazard", {31'h0, w_raw_hazard_out}, 32'h0);
        chk("alu_n2_commit_valid", {31'h0, w_commit_valid}, 32'h1);

        // Byte and word loads, back to back
        tick();
        issue(2'b01, 5'd7, 32'h12F45678, 2'b01, 32'h0, 32'h0, 32'hFFFFFFF4);
        tick();
        issue(2'b01, 5'd8, 32'h12F45678, 2'b00, 32'h0, 32'h0, 32'h00000012);
        tick();
        issue(2'b01, 5'd10, 32'h12F45678, 2'b11, 32'h0, 32'h0, 32'h00000078);
        tick();
        issue(2'b01, 5'd11, 32'h82F456A9, 2'b10, 32'h0, 32'h0, 32'h00000056);
        tick();
        issue(2'b00, 5'd12, 32'hCAFEF00D, 2'b11, 32'h0, 32'h0, 32'hCAFEF00D);
        tick();
        idle();
        repeat (2) tick();
        read_chk("byte_lo01", 5'd7, 32'hFFFFFFF4);
        read_chk("byte_lo00", 5'd8, 32'h00000012);
        read_chk("byte_lo11", 5'd10, 32'h00000078);
        read_chk("byte_lo10", 5'd11, 32'h00000056);
        read_chk("mem_word", 5'd12, 32'hCAFEF00D);

        // Write to register 0 is dropped
        tick();
        issue(2'b10, 5'd0, 32'h0, 2'b00, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF);
        read_chk("r0_n0", 5'd0, 32'h0);
        tick();
        idle();
        read_chk("r0_n1", 5'd0, 32'h0);
        chk("r0_n1_hazard", {31'h0, w_raw_hazard_out}, 32'h0);
        tick();
        read_chk("r0_n2", 5'd0, 32'h0);
        chk("r0_n2_commit_valid", {31'h0, w_commit_valid}, 32'h0);

        // Back-to-back writes to r3
        tick();
        w_raddr_a_5 = 5'd0;
        w_raddr_b_5 = 5'd3;
        issue(2'b10, 5'd3, 32'h0, 2'b00, 32'h11, 32'h0, 32'h11);
        tick();
        issue(2'b11, 5'd3, 32'h0, 2'b00, 32'h0, 32'h22, 32'h22);
`ifdef REG_FILE_BYPASS_EN
        chk("b2b_n1", w_rdata_b_32, 32'h11);
`else
        chk("b2b_n1", w_rdata_b_32, 32'h0);
`endif
        tick();
        idle();
`ifdef REG_FILE_BYPASS_EN
        chk("b2b_n2", w_rdata_b_32, 32'h22);
`else
        chk("b2b_n2", w_rdata_b_32, 32'h11);
`endif
        tick();
        chk("b2b_n3", w_rdata_b_32, 32'h22);
        tick();
        read_chk("b2b_n4", 5'd3, 32'h22);

        // Reset asserted while a write to r9 is in stage 1
        repeat (2) tick();
        issue(2'b10, 5'd9, 32'h0, 2'b00, 32'h55, 32'h0, 32'h55);
        void'(exp_q.pop_back());
        tick();
        idle();
        reset = 1'b0;
        #1;
        chk("midrst_commit_valid", {31'h0, w_commit_valid}, 32'h0);
        read_chk("midrst_r5", 5'd5, 32'h0);
        tick();
        chk("midrst_commit_valid2", {31'h0, w_commit_valid}, 32'h0);
        reset = 1'b1;
        issue(2'b10, 5'd9, 32'h0, 2'b00, 32'h66, 32'h0, 32'h66);
        read_chk("midrst_r9", 5'd9, 32'h0);
        tick();
        idle();
        tick();
        read_chk("post_rst_r9", 5'd9, 32'h66);
        read_chk("post_rst_r3", 5'd3, 32'h0);

        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
